// File: rtl/postsyn_pkg.sv
// Shared types and default constants for the postsynaptic neuron.
package postsyn_pkg;

  typedef enum logic {
    INTEGRATE  = 1'b0,
    REFRACTORY = 1'b1
  } state_t;

  localparam int DEF_WIDTH          = 8;
  localparam int DEF_W_WIDTH        = 4;
  localparam int DEF_LEAK_PERIOD    = 16;
  localparam int DEF_LEAK_AMT       = 1;
  localparam int DEF_REFRACT_CYCLES = 8;

endpackage

// File: rtl/spike_edge_detect.sv
// Rising-edge detector for one synchronous spike level input.
module spike_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic evt
);

  logic prev;

  // History tracks the input every cycle, independent of enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= in;
  end

  assign evt = in & ~prev;

endmodule

// File: rtl/postsynaptic_neuron.sv
// Leaky integrate-and-fire neuron fed by two synapse spike inputs.
module postsynaptic_neuron
  import postsyn_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int W_WIDTH        = DEF_W_WIDTH,
  parameter int LEAK_PERIOD    = DEF_LEAK_PERIOD,
  parameter int LEAK_AMT       = DEF_LEAK_AMT,
  parameter int REFRACT_CYCLES = DEF_REFRACT_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               spike_a_in,
  input  logic               spike_b_in,
  input  logic [W_WIDTH-1:0] weight_a,
  input  logic [W_WIDTH-1:0] weight_b,
  input  logic [WIDTH-1:0]   threshold,
  output logic               spike_out,
  output logic [WIDTH-1:0]   potential,
  output logic               refractory,
  output logic [7:0]         spike_count
);

  localparam int LW = $clog2(LEAK_PERIOD);
  localparam int RW = (REFRACT_CYCLES > 1) ? $clog2(REFRACT_CYCLES) : 1;
  localparam int SW = WIDTH + 2;

  localparam logic [LW-1:0] LEAK_LAST = LW'(LEAK_PERIOD - 1);
  localparam logic [RW-1:0] REFR_INIT = RW'(REFRACT_CYCLES - 1);
  localparam logic signed [SW-1:0] POT_MAX = SW'((1 << WIDTH) - 1);

  state_t state, state_d;
  logic [LW-1:0] lcnt;
  logic [RW-1:0] rcnt, rcnt_d;
  logic [WIDTH-1:0] pot_d;
  logic [7:0] count_d;
  logic spike_d;
  logic ev_a, ev_b;
  logic leak_tick, fire;
  logic signed [SW-1:0] pot_s, add_a, add_b, leak_v, sum;
  logic [WIDTH-1:0] clamped;

  spike_edge_detect u_edge_a (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (spike_a_in),
    .evt   (ev_a)
  );

  spike_edge_detect u_edge_b (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (spike_b_in),
    .evt   (ev_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt <= '0;
    end else if (ena) begin
      lcnt <= (lcnt == LEAK_LAST) ? '0 : lcnt + 1'b1;
    end
  end

  assign leak_tick = (lcnt == LEAK_LAST);
  assign fire = (threshold != '0) && (potential >= threshold);

  // Signed headroom lets add and leak net out before clamping.
  assign pot_s  = SW'(potential);
  assign add_a  = ev_a ? SW'(weight_a) : '0;
  assign add_b  = ev_b ? SW'(weight_b) : '0;
  assign leak_v = leak_tick ? SW'(LEAK_AMT) : '0;
  assign sum    = pot_s + add_a + add_b - leak_v;

  always_comb begin
    clamped = sum[WIDTH-1:0];
    if (sum < 0)            clamped = '0;
    else if (sum > POT_MAX) clamped = '1;
  end

  always_comb begin
    state_d = state;
    rcnt_d  = rcnt;
    pot_d   = potential;
    count_d = spike_count;
    spike_d = 1'b0;
    if (ena) begin
      unique case (state)
        INTEGRATE: begin
          if (fire) begin
            spike_d = 1'b1;
            pot_d   = '0;
            count_d = spike_count + 8'd1;
            rcnt_d  = REFR_INIT;
            state_d = REFRACTORY;
          end else begin
            pot_d = clamped;
          end
        end
        REFRACTORY: begin
          pot_d = '0;
          if (rcnt == '0) state_d = INTEGRATE;
          else            rcnt_d  = rcnt - 1'b1;
        end
        default: state_d = INTEGRATE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INTEGRATE;
      rcnt        <= '0;
      potential   <= '0;
      spike_count <= '0;
      spike_out   <= 1'b0;
    end else begin
      state       <= state_d;
      rcnt        <= rcnt_d;
      potential   <= pot_d;
      spike_count <= count_d;
      spike_out   <= spike_d;
    end
  end

  assign refractory = (state == REFRACTORY);

endmodule

// File: tb/tb_postsynaptic_neuron.sv
// Directed and randomized checks of the neuron against a behavioural model.
module tb_postsynaptic_neuron;

  localparam int LP = 16;
  localparam int LA = 1;
  localparam int RC = 8;
  localparam int PMAX = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  logic spike_a_in = 1'b0;
  logic spike_b_in = 1'b0;
  logic [3:0] weight_a = '0;
  logic [3:0] weight_b = '0;
  logic [7:0] threshold = '0;
  logic spike_out;
  logic [7:0] potential;
  logic refractory;
  logic [7:0] spike_count;

  int total = 0;
  int passed = 0;

  int m_pot, m_refr, m_lcnt, m_cnt;
  bit m_pa, m_pb, m_spike;

  always #5 clk = ~clk;

  postsynaptic_neuron dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .spike_a_in  (spike_a_in),
    .spike_b_in  (spike_b_in),
    .weight_a    (weight_a),
    .weight_b    (weight_b),
    .threshold   (threshold),
    .spike_out   (spike_out),
    .potential   (potential),
    .refractory  (refractory),
    .spike_count (spike_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pot = 0; m_refr = 0; m_lcnt = 0; m_cnt = 0;
    m_pa = 0; m_pb = 0; m_spike = 0;
  endtask

  // One clock of the neuron's rules, in plain integer arithmetic.
  task automatic model(input bit e, input bit a, input bit b);
    bit ea, eb, tick;
    int n;
    ea = a && !m_pa;
    eb = b && !m_pb;
    m_pa = a;
    m_pb = b;
    m_spike = 0;
    if (e) begin
      tick = (m_lcnt == LP - 1);
      m_lcnt = (m_lcnt + 1) % LP;
      if (m_refr > 0) begin
        m_refr--;
        m_pot = 0;
      end else if (threshold != 0 && m_pot >= int'(threshold)) begin
        m_spike = 1;
        m_pot = 0;
        m_cnt = (m_cnt + 1) % 256;
        m_refr = RC;
      end else begin
        n = m_pot + (ea ? int'(weight_a) : 0) + (eb ? int'(weight_b) : 0)
            - (tick ? LA : 0);
        m_pot = (n < 0) ? 0 : (n > PMAX) ? PMAX : n;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pot"}, 32'(potential), 32'(m_pot));
    chk({tag, ".spk"}, 32'(spike_out), 32'(m_spike));
    chk({tag, ".ref"}, 32'(refractory), 32'(m_refr > 0));
    chk({tag, ".cnt"}, 32'(spike_count), 32'(m_cnt));
  endtask

  task automatic step(input bit e, input bit a, input bit b,
                      input string tag);
    ena = e;
    spike_a_in = a;
    spike_b_in = b;
    @(posedge clk);
    model(e, a, b);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    ena = 0;
    spike_a_in = 0;
    spike_b_in = 0;
    rst_n = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    // 1: reset and idle leak
    do_reset();
    check_all("reset");
    repeat (20) step(1, 0, 0, "idle");
    chk("idle.cnt0", 32'(spike_count), 32'd0);
    chk("idle.pot0", 32'(potential), 32'd0);

    // 2: integrate to threshold and fire
    do_reset();
    threshold = 8'd10;
    weight_a = 4'd4;
    step(1, 1, 0, "t2");
    chk("t2.p4", 32'(potential), 32'd4);
    repeat (2) step(1, 0, 0, "t2");
    step(1, 1, 0, "t2");
    chk("t2.p8", 32'(potential), 32'd8);
    repeat (2) step(1, 0, 0, "t2");
    step(1, 1, 0, "t2");
    chk("t2.p12", 32'(potential), 32'd12);
    chk("t2.nospk", 32'(spike_out), 32'd0);
    step(1, 0, 0, "t2");
    chk("t2.spk", 32'(spike_out), 32'd1);
    chk("t2.pot0", 32'(potential), 32'd0);
    chk("t2.cnt1", 32'(spike_count), 32'd1);
    for (int i = 0; i < 7; i++) begin
      chk("t2.refr", 32'(refractory), 32'd1);
      step(1, 0, 0, "t2r");
      chk("t2.spk1cyc", 32'(spike_out), 32'd0);
    end
    chk("t2.refr8", 32'(refractory), 32'd1);
    step(1, 0, 0, "t2x");
    chk("t2.exit", 32'(refractory), 32'd0);

    // 3: saturation with firing disabled
    do_reset();
    threshold = 8'd0;
    weight_a = 4'd15;
    weight_b = 4'd15;
    for (int i = 0; i < 40 && m_pot < 240; i++) begin
      step(1, 1, 1, "t3");
      step(1, 0, 0, "t3");
    end
    step(1, 1, 1, "t3");
    chk("t3.sat", 32'(potential), 32'd255);
    chk("t3.nospk", 32'(spike_out), 32'd0);
    repeat (6) begin
      step(1, 0, 0, "t3");
      step(1, 1, 1, "t3");
    end
    chk("t3.hold", 32'(potential), 32'd255);

    // 4: leak to zero without underflow
    do_reset();
    weight_a = 4'd3;
    step(1, 1, 0, "t4");
    chk("t4.p3", 32'(potential), 32'd3);
    repeat (15) step(1, 0, 0, "t4");
    chk("t4.p2", 32'(potential), 32'd2);
    repeat (16) step(1, 0, 0, "t4");
    chk("t4.p1", 32'(potential), 32'd1);
    repeat (16) step(1, 0, 0, "t4");
    chk("t4.p0", 32'(potential), 32'd0);
    repeat (20) step(1, 0, 0, "t4");
    chk("t4.floor", 32'(potential), 32'd0);

    // 5: events during refractory are lost
    do_reset();
    threshold = 8'd10;
    weight_a = 4'd7;
    weight_b = 4'd7;
    step(1, 1, 0, "t5");
    step(1, 0, 0, "t5");
    step(1, 1, 0, "t5");
    step(1, 0, 0, "t5");
    chk("t5.fire", 32'(spike_out), 32'd1);
    step(1, 1, 0, "t5");
    step(1, 0, 0, "t5");
    repeat (15) step(1, 0, 1, "t5");
    chk("t5.out", 32'(refractory), 32'd0);
    chk("t5.pot", 32'(potential), 32'd0);

    // 6: asynchronous reset mid-refractory
    do_reset();
    threshold = 8'd4;
    weight_a = 4'd15;
    repeat (5) begin
      step(1, 1, 0, "t6");
      step(1, 0, 0, "t6");
      repeat (8) step(1, 0, 0, "t6");
    end
    chk("t6.cnt5", 32'(spike_count), 32'd5);
    step(1, 1, 0, "t6");
    step(1, 0, 0, "t6");
    step(1, 0, 0, "t6");
    chk("t6.inref", 32'(refractory), 32'd1);
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("t6.apot", 32'(potential), 32'd0);
    chk("t6.aref", 32'(refractory), 32'd0);
    chk("t6.acnt", 32'(spike_count), 32'd0);
    chk("t6.aspk", 32'(spike_out), 32'd0);
    @(posedge clk);
    #1 rst_n = 1;
    step(1, 1, 0, "t6post");
    chk("t6.integ", 32'(potential), 32'd15);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) begin
        threshold = 8'($urandom_range(0, 60));
        weight_a = 4'($urandom);
        weight_b = 4'($urandom);
      end
      step($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom), "rnd");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
